// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one uart_tx between NUM_REQ byte streams.
// One byte in flight at a time, paced on uart_busy; idle grants are reclaimed after IDLE_TIMEOUT.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int GRANT_W      = 1,
  parameter int ACK_TIMEOUT  = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                   clk_100MHz,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             uart_data,
  output logic                   write_en,
  input  logic                   uart_busy,
  output logic [GRANT_W-1:0]     grant_id,
  output logic                   grant_active,
  output logic                   ack_err
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t             state_q;
  logic [GRANT_W-1:0] grant_id_q;
  logic [GRANT_W-1:0] last_grant_q;
  logic               grant_active_q;
  logic               write_en_q;
  logic [7:0]         uart_data_q;
  logic               last_q;
  logic               ack_err_q;
  logic [IDLE_W-1:0]  idle_cnt_q;
  logic [ACK_W-1:0]   ack_cnt_q;

  logic               win_found_d;
  logic [GRANT_W-1:0] win_id_d;
  logic               gsel_valid;
  logic               gsel_last;
  logic [7:0]         gsel_data;
  logic               hs;

  // Scan starts one past the last winner so every requester gets its turn.
  always_comb begin
    win_found_d = 1'b0;
    win_id_d    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [GRANT_W-1:0] idx;
      idx = GRANT_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!win_found_d && req_valid[idx]) begin
        win_found_d = 1'b1;
        win_id_d    = idx;
      end
    end
  end

  always_comb begin
    gsel_valid = 1'b0;
    gsel_last  = 1'b0;
    gsel_data  = '0;
    req_ready  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id_q == GRANT_W'(k)) begin
        gsel_valid   = req_valid[k];
        gsel_last    = req_last[k];
        gsel_data    = req_data[8*k +: 8];
        req_ready[k] = (state_q == S_HOLD) && !uart_busy;
      end
    end
    hs = gsel_valid && (state_q == S_HOLD) && !uart_busy;
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q        <= S_IDLE;
      grant_id_q     <= '0;
      last_grant_q   <= GRANT_W'(NUM_REQ - 1);
      grant_active_q <= 1'b0;
      write_en_q     <= 1'b0;
      uart_data_q    <= '0;
      last_q         <= 1'b0;
      ack_err_q      <= 1'b0;
      idle_cnt_q     <= '0;
      ack_cnt_q      <= '0;
    end else begin
      write_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            grant_id_q     <= win_id_d;
            grant_active_q <= 1'b1;
            idle_cnt_q     <= '0;
            state_q        <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hs) begin
            uart_data_q <= gsel_data;
            last_q      <= gsel_last;
            write_en_q  <= 1'b1;
            state_q     <= S_ISSUE;
          end else if (gsel_valid) begin
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
            grant_active_q <= 1'b0;
            last_grant_q   <= grant_id_q;
            state_q        <= S_IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        S_ISSUE: begin
          ack_cnt_q <= '0;
          state_q   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (uart_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
            // Transmitter never acknowledged; flag it but keep the stream moving.
            ack_err_q <= 1'b1;
            state_q   <= S_WAIT_DONE;
          end else begin
            ack_cnt_q <= ack_cnt_q + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!uart_busy) begin
            if (last_q) begin
              grant_active_q <= 1'b0;
              last_grant_q   <= grant_id_q;
              state_q        <= S_IDLE;
            end else begin
              idle_cnt_q <= '0;
              state_q    <= S_HOLD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign uart_data    = uart_data_q;
  assign write_en     = write_en_q;
  assign grant_id     = grant_id_q;
  assign grant_active = grant_active_q;
  assign ack_err      = ack_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requesters, a uart_tx busy model and a TX log.
module tb_uart_tx_arbiter;

  logic        clk_100MHz = 1'b0;
  logic        rst        = 1'b1;
  logic [1:0]  req_valid  = '0;
  logic [15:0] req_data   = '0;
  logic [1:0]  req_last   = '0;
  logic [1:0]  req_ready;
  logic [7:0]  uart_data;
  logic        write_en;
  logic        uart_busy  = 1'b0;
  logic [0:0]  grant_id;
  logic        grant_active;
  logic        ack_err;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit bm_en = 1'b1;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] tx_b[$];
  int         tx_g[$];
  int         tx_c[$];

  uart_tx_arbiter dut (
    .clk_100MHz  (clk_100MHz),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .uart_data   (uart_data),
    .write_en    (write_en),
    .uart_busy   (uart_busy),
    .grant_id    (grant_id),
    .grant_active(grant_active),
    .ack_err     (ack_err)
  );

  initial forever #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Requester model: present queue heads, pop on handshake.
  initial begin
    logic [1:0] hs;
    forever begin
      @(posedge clk_100MHz);
      hs = req_valid & req_ready;
      #1;
      if (hs[0] && q0.size() > 0) void'(q0.pop_front());
      if (hs[1] && q1.size() > 0) void'(q1.pop_front());
      req_valid[0]   = (q0.size() > 0);
      req_last[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
      req_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      req_valid[1]   = (q1.size() > 0);
      req_last[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
      req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    end
  end

  // uart_tx model: busy for three cycles after each start pulse.
  initial forever begin
    @(posedge clk_100MHz);
    if (write_en && bm_en) begin
      #1 uart_busy = 1'b1;
      repeat (3) @(posedge clk_100MHz);
      #1 uart_busy = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk_100MHz);
    cyc++;
    if (write_en) begin
      tx_b.push_back(uart_data);
      tx_g.push_back(int'(grant_id));
      tx_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    repeat (3) tick();
    tx_b.delete();
    tx_g.delete();
    tx_c.delete();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_we(input int budget);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!write_en && k < budget);
    if (!write_en) chk("write_en_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && req_valid == 2'b00 &&
             !grant_active && !uart_busy) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_tx(input string tag, input int i, input logic [7:0] exp_b, input int exp_g);
    chk($sformatf("%s_byte[%0d]", tag, i),
        (i < tx_b.size()) ? 32'(tx_b[i]) : 32'hFFFF_FFFF, 32'(exp_b));
    chk($sformatf("%s_grant[%0d]", tag, i),
        (i < tx_g.size()) ? 32'(tx_g[i]) : 32'hFFFF_FFFF, 32'(exp_g));
  endtask

  initial begin
    int k;
    int n0;
    logic [7:0] eb[5];
    int         eg[5];

    do_reset();
    rst = 1'b1;
    tick();
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_uart_data", 32'(uart_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_grant_active", 32'(grant_active), 32'd0);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single byte
    q0.push_back({1'b1, 8'h50});
    wait_we(50);
    chk("t1_uart_data", 32'(uart_data), 32'h50);
    k = 0;
    while (grant_active && k < 20) begin
      tick();
      k++;
    end
    chk("t1_release_delay", 32'(k), 32'd5);
    chk("t1_busy_at_release", 32'(uart_busy), 32'd0);
    wait_done(50);
    chk("t1_n_tx", 32'(tx_b.size()), 32'd1);
    chk_tx("t1", 0, 8'h50, 0);

    // 2: contention right after reset
    do_reset();
    q0.push_back({1'b0, 8'h50});
    q0.push_back({1'b0, 8'h43});
    q0.push_back({1'b1, 8'h3D});
    q1.push_back({1'b0, 8'h41});
    q1.push_back({1'b1, 8'h42});
    wait_done(300);
    eb = '{8'h50, 8'h43, 8'h3D, 8'h41, 8'h42};
    eg = '{0, 0, 0, 1, 1};
    chk("t2_n_tx", 32'(tx_b.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk_tx("t2", i, eb[i], eg[i]);

    // 3: round-robin over single-byte messages
    do_reset();
    q0.push_back({1'b1, 8'h61});
    q0.push_back({1'b1, 8'h62});
    q1.push_back({1'b1, 8'h71});
    q1.push_back({1'b1, 8'h72});
    wait_done(300);
    eb[0:3] = '{8'h61, 8'h71, 8'h62, 8'h72};
    eg[0:3] = '{0, 1, 0, 1};
    chk("t3_n_tx", 32'(tx_b.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_tx("t3", i, eb[i], eg[i]);

    // 4: stuck requester released by idle timeout
    do_reset();
    q0.push_back({1'b0, 8'h11});
    q1.push_back({1'b1, 8'h22});
    wait_done(3000);
    chk("t4_n_tx", 32'(tx_b.size()), 32'd2);
    chk_tx("t4", 0, 8'h11, 0);
    chk_tx("t4", 1, 8'h22, 1);
    chk("t4_gap", (tx_c.size() == 2) ? 32'(tx_c[1] - tx_c[0]) : 32'hFFFF_FFFF, 32'd1031);

    // 5: transmitter never acknowledges
    do_reset();
    bm_en = 1'b0;
    q0.push_back({1'b0, 8'h33});
    q0.push_back({1'b1, 8'h34});
    wait_we(50);
    repeat (4) tick();
    chk("t5_ack_err_early", 32'(ack_err), 32'd0);
    tick();
    chk("t5_ack_err", 32'(ack_err), 32'd1);
    wait_done(100);
    chk("t5_n_tx", 32'(tx_b.size()), 32'd2);
    chk_tx("t5", 1, 8'h34, 0);
    chk("t5_ack_err_sticky", 32'(ack_err), 32'd1);
    bm_en = 1'b1;

    // 6: reset while waiting for the byte to finish
    do_reset();
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b1, 8'h42});
    wait_we(50);
    repeat (2) tick();
    chk("t6_pre_grant_active", 32'(grant_active), 32'd1);
    rst = 1'b1;
    q0.delete();
    tick();
    chk("t6_write_en", 32'(write_en), 32'd0);
    chk("t6_uart_data", 32'(uart_data), 32'd0);
    chk("t6_grant_id", 32'(grant_id), 32'd0);
    chk("t6_grant_active", 32'(grant_active), 32'd0);
    chk("t6_ack_err", 32'(ack_err), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    n0 = tx_b.size();
    repeat (20) tick();
    chk("t6_no_write_en", 32'(tx_b.size()), 32'(n0));
    q0.push_back({1'b1, 8'h55});
    wait_done(100);
    chk("t6_n_tx", 32'(tx_b.size()), 32'(n0 + 1));
    chk_tx("t6", n0, 8'h55, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
